// File: rtl/qft_shot_sampler_pkg.sv
// Shared types and constants for the qft_shot_sampler measurement stage.
// TOTAL_BITS normally comes from the fixed-point utilities header; a 16-bit default applies if it is absent.
`ifndef TOTAL_BITS
`define TOTAL_BITS 16
`endif

package qft_shot_sampler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int              LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

    localparam int MAG_W = `TOTAL_BITS;
    localparam int CDF_W = `TOTAL_BITS + 2;

    // Probabilities are non-negative; a negative fixed-point input counts as zero.
    function automatic logic [CDF_W-1:0] clamp_mag(input logic [MAG_W-1:0] m);
        return m[MAG_W-1] ? '0 : CDF_W'(m);
    endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit right-shifting Galois LFSR with synchronous load; zero seeds are forced to 1.
module lfsr16_galois
    import qft_shot_sampler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] value
);

    localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? 16'h0001 : SEED;

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (load_val == '0) ? 16'h0001 : load_val;
        end else if (advance) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= SEED_NZ;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/qft_shot_sampler.sv
// Draws SHOTS measurement outcomes from four |amp|^2 values and accumulates a 4-bin histogram.
// Optional macro QFT_SAMPLER_SEED_LOAD_EN adds seed_load/seed_in for reseeding the LFSR while idle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; outputs hold the last run's results
// LOAD    | latch magnitudes, build CDF, clear histogram and err
// RUN     | one draw per cycle until SHOTS draws are made
// DONE    | one-cycle done pulse
module qft_shot_sampler
    import qft_shot_sampler_pkg::*;
#(
    parameter int unsigned       SHOTS     = 256,
    parameter int unsigned       CNT_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef QFT_SAMPLER_SEED_LOAD_EN
    input  logic                 seed_load,
    input  logic [LFSR_W-1:0]    seed_in,
`endif
    input  logic [MAG_W*4-1:0]   mag_sq_in,
    output logic                 busy,
    output logic                 shot_valid,
    output logic [1:0]           shot_idx,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W*4-1:0]   hist_out
);

    state_e state_q, state_d;

    logic [CDF_W-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d, total_q, total_d;
    logic [CNT_W-1:0] hist_q [4];
    logic [CNT_W-1:0] hist_d [4];
    logic [15:0]      shot_cnt_q, shot_cnt_d;
    logic             shot_valid_q, shot_valid_d;
    logic [1:0]       shot_idx_q, shot_idx_d;
    logic             err_q, err_d;

    logic [CDF_W-1:0] m0, m1, m2, m3;
    logic [CDF_W-1:0] c0_in, c1_in, c2_in, total_in;
    logic [LFSR_W-1:0] lfsr_val;
    logic [LFSR_W-1:0] lfsr_load_val;
    logic              lfsr_load;
    logic              lfsr_advance;
    logic [LFSR_W+CDF_W-1:0] prod;
    logic [CDF_W-1:0]  r;
    logic [1:0]        idx;
    logic              last_shot;

    assign m0 = clamp_mag(mag_sq_in[4*MAG_W-1 -: MAG_W]);
    assign m1 = clamp_mag(mag_sq_in[3*MAG_W-1 -: MAG_W]);
    assign m2 = clamp_mag(mag_sq_in[2*MAG_W-1 -: MAG_W]);
    assign m3 = clamp_mag(mag_sq_in[1*MAG_W-1 -: MAG_W]);

    assign c0_in    = m0;
    assign c1_in    = c0_in + m1;
    assign c2_in    = c1_in + m2;
    assign total_in = c2_in + m3;

    // Scaling a uniform 16-bit value by total keeps r strictly below total.
    assign prod = (LFSR_W+CDF_W)'(lfsr_val) * (LFSR_W+CDF_W)'(total_q);
    assign r    = CDF_W'(prod >> LFSR_W);

    always_comb begin
        idx = 2'd3;
        if (r < c0_q) begin
            idx = 2'd0;
        end else if (r < c1_q) begin
            idx = 2'd1;
        end else if (r < c2_q) begin
            idx = 2'd2;
        end
    end

    assign last_shot    = (shot_cnt_q == 16'(SHOTS - 1));
    assign lfsr_advance = (state_q == ST_RUN);

`ifdef QFT_SAMPLER_SEED_LOAD_EN
    assign lfsr_load     = seed_load && (state_q == ST_IDLE);
    assign lfsr_load_val = seed_in;
`else
    assign lfsr_load     = 1'b0;
    assign lfsr_load_val = '0;
`endif

    lfsr16_galois #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (lfsr_advance),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .value    (lfsr_val)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: state_d = (total_in == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (last_shot) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        c0_d         = c0_q;
        c1_d         = c1_q;
        c2_d         = c2_q;
        total_d      = total_q;
        shot_cnt_d   = shot_cnt_q;
        shot_idx_d   = shot_idx_q;
        shot_valid_d = 1'b0;
        err_d        = err_q;
        for (int i = 0; i < 4; i++) begin
            hist_d[i] = hist_q[i];
        end
        case (state_q)
            ST_LOAD: begin
                c0_d       = c0_in;
                c1_d       = c1_in;
                c2_d       = c2_in;
                total_d    = total_in;
                shot_cnt_d = '0;
                err_d      = (total_in == '0);
                for (int i = 0; i < 4; i++) begin
                    hist_d[i] = '0;
                end
            end
            ST_RUN: begin
                shot_valid_d = 1'b1;
                shot_idx_d   = idx;
                shot_cnt_d   = shot_cnt_q + 16'd1;
                if (hist_q[idx] != '1) begin
                    hist_d[idx] = hist_q[idx] + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c0_q         <= '0;
            c1_q         <= '0;
            c2_q         <= '0;
            total_q      <= '0;
            shot_cnt_q   <= '0;
            shot_valid_q <= 1'b0;
            shot_idx_q   <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            c0_q         <= c0_d;
            c1_q         <= c1_d;
            c2_q         <= c2_d;
            total_q      <= total_d;
            shot_cnt_q   <= shot_cnt_d;
            shot_valid_q <= shot_valid_d;
            shot_idx_q   <= shot_idx_d;
            err_q        <= err_d;
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign shot_valid = shot_valid_q;
    assign shot_idx   = shot_idx_q;
    assign err        = err_q;
    assign hist_out   = {hist_q[0], hist_q[1], hist_q[2], hist_q[3]};

endmodule
